// File: rtl/mod_loader_pkg.sv
// Shared modulation constants: BRAM geometry and loader state encoding.
// The modulator imports this package so both sides agree on the same values.
package mod_loader_pkg;

    localparam int ADDR_WIDTH_DEF = 15;
    localparam int CNT_WIDTH      = 17;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOW    = 3'd1,
        ST_HIGH   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_COMMIT = 3'd4
    } load_state_e;

endpackage

// File: rtl/mod_loader.sv
// Streams modulation bytes into the 16-bit modulation BRAM and commits the cycle
// length only once the whole table has been written.
//
// state  | meaning
// IDLE   | no load in progress, VALID ignored
// LOW    | waiting for the even byte of a word
// HIGH   | waiting for the odd byte; handshake issues the word write
// FLUSH  | odd byte count: last half-word write is on the bus
// COMMIT | publish the latched length to CYCLE and pulse DONE
module mod_loader
    import mod_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [15:0]           CYCLE_IN,
    input  logic [7:0]            DATA_IN,
    input  logic                  VALID,
    output logic                  READY,
    output logic                  BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [15:0]           BRAM_DIN,
    output logic [15:0]           CYCLE,
    output logic                  BUSY,
    output logic                  DONE
);

    load_state_e           state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [7:0]            low_q, low_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           din_q, din_d;
    logic [15:0]           cycle_q, cycle_d;
    logic                  done_q, done_d;

    logic                  ready;
    logic                  xfer;
    logic                  last_byte;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign ready     = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign xfer      = VALID && ready;
    assign last_byte = (cnt_q == {1'b0, len_q});
    assign word_addr = ADDR_WIDTH'(cnt_q >> 1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        low_d   = low_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        cycle_d = cycle_q;
        done_d  = 1'b0;

        // START wins in every state, which also aborts a load still in flight
        if (START) begin
            state_d = ST_LOW;
            len_d   = CYCLE_IN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOW: begin
                    if (xfer) begin
                        low_d = DATA_IN;
                        cnt_d = cnt_q + 1'b1;
                        if (last_byte) begin
                            we_d    = 1'b1;
                            addr_d  = word_addr;
                            din_d   = {8'h00, DATA_IN};
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_HIGH;
                        end
                    end
                end
                ST_HIGH: begin
                    if (xfer) begin
                        cnt_d   = cnt_q + 1'b1;
                        we_d    = 1'b1;
                        addr_d  = word_addr;
                        din_d   = {DATA_IN, low_q};
                        state_d = last_byte ? ST_COMMIT : ST_LOW;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_COMMIT;
                end
                ST_COMMIT: begin
                    cycle_d = len_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            low_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            cycle_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cycle_q <= cycle_d;
            done_q  <= done_d;
        end
    end

    assign READY     = ready;
    assign BUSY      = (state_q != ST_IDLE);
    assign BRAM_WE   = we_q;
    assign BRAM_ADDR = addr_q;
    assign BRAM_DIN  = din_q;
    assign CYCLE     = cycle_q;
    assign DONE      = done_q;

endmodule

// File: doc/mod_loader.md
MOD_LOADER -- requirements
Module: mod_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, meaning the modulation BRAM word-address width (2^15 words of 16 bits = 65536 bytes).
REQ-002 SHALL have port CLK  input  1  system clock (20.48 MHz domain); all logic is on its rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port START  input  1  single-cycle pulse that begins a load.
REQ-005 SHALL have port CYCLE_IN  input  16  byte count minus one for the load; sampled on START.
REQ-006 SHALL have port DATA_IN  input  8  modulation byte.
REQ-007 SHALL have port VALID  input  1  DATA_IN is valid.
REQ-008 SHALL have port READY  output  1  loader accepts DATA_IN this cycle.
REQ-009 SHALL have port BRAM_WE  output  1  write strobe to the modulation BRAM write port.
REQ-010 SHALL have port BRAM_ADDR  output  ADDR_WIDTH  word address.
REQ-011 SHALL have port BRAM_DIN  output  16  write data: byte 2k in [7:0], byte 2k+1 in [15:8].
REQ-012 SHALL have port CYCLE  output  16  committed cycle value, consumed by the modulator.
REQ-013 SHALL have port BUSY  output  1  a load is in progress.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse when a load commits.

Function
REQ-015 SHALL implement states IDLE, LOW, HIGH, FLUSH and COMMIT.
REQ-016 SHALL, in IDLE on START, latch CYCLE_IN, clear the byte counter and go to LOW.
REQ-017 SHALL assert READY only in LOW and HIGH; a byte transfers when VALID and READY are both high.
REQ-018 SHALL, in LOW, store the byte in the low half of the word register and go to HIGH, or go to FLUSH if it is the last byte.
REQ-019 SHALL, in HIGH, issue BRAM_WE for one cycle with BRAM_ADDR = counter>>1 and the full word, then go to LOW, or go to COMMIT if it is the last byte.
REQ-020 SHALL, in FLUSH (odd byte count), write the word with [15:8]=0 for one cycle, then go to COMMIT.
REQ-021 SHALL define the last byte as the byte whose counter equals the latched CYCLE_IN.
REQ-022 SHALL, in COMMIT, load CYCLE from the latched value, pulse DONE for exactly one cycle and return to IDLE.
REQ-023 SHALL have CYCLE change only in COMMIT, so the modulator never sees a cycle value from a partial load.
REQ-024 SHALL drive BUSY high in every state except IDLE.
REQ-025 SHALL register the BRAM write, 1-cycle latency from the high-byte handshake; at most one write per cycle.
REQ-026 SHALL, if START occurs while BUSY, abort the load (CYCLE unchanged, no DONE) and restart as in REQ-016 on the same edge.
REQ-027 SHALL ignore VALID while in IDLE; bytes are not buffered.
REQ-028 SHALL handle CYCLE_IN=0 as a one-byte load: LOW, then FLUSH, then COMMIT.
REQ-029 SHALL handle CYCLE_IN=16'hFFFF as a 65536-byte load whose last write goes to BRAM_ADDR=32767 with no wrap of the counter.
REQ-030 SHALL use a 17-bit internal byte counter to avoid overflow.

Reset
REQ-031 SHALL set the following on RST: state IDLE, READY=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DIN=0, CYCLE=0, BUSY=0, DONE=0, and the counter and latched length to 0.
REQ-032 SHALL, when RST asserts during a load, discard the load with no write and no DONE after release.

Structure
REQ-033 SHALL place the state enum and ADDR_WIDTH default in the shared modulation package so the modulator uses the same constants.
REQ-034 SHALL be a single module with no sub-modules; the BRAM stays outside the module.

Verification
REQ-035 SHALL verify the even load: CYCLE_IN=999 with 1000 random bytes at VALID=1 gives 500 writes at addresses 0..499, then DONE, then CYCLE=999, and modulator output equals duty*mod/255 for every index.
REQ-036 SHALL verify the odd load: CYCLE_IN=2 with bytes 0x11,0x22,0x33 gives a write to addr0 of 0x2211, a write to addr1 of 0x0033, and CYCLE=2.
REQ-037 SHALL verify backpressure: VALID toggled randomly at 50% over a 257-byte load gives the same BRAM contents as a continuous load and exactly one DONE.
REQ-038 SHALL verify restart: START mid-load at byte 10, followed by a new 4-byte load, gives no DONE for the first load and CYCLE=3 after the second.
REQ-039 SHALL verify the full load: CYCLE_IN=16'hFFFF gives a last write at addr 32767, CYCLE=65535, and no write to addr 0 after the first.
REQ-040 SHALL verify reset: RST asserted at byte 5 of a load gives all outputs at reset values and CYCLE keeping its previous value of 0.
